// File: rtl/matrix_dma_bridge.sv
// Matrix accelerator DMA port to Wishbone classic single-transfer bridge.
// One dma_req/dma_ack word becomes one bus read or write, with timeout and error capture.
module matrix_dma_bridge #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        err_clr,
  output logic        err_o,
  output logic [1:0]  err_code,
  output logic [15:0] xfer_count
);

  localparam int unsigned LW = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned CW = (LW > 9) ? LW : 9;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [1:0] E_BUS = 2'b01;
  localparam logic [1:0] E_TMO = 2'b10;
  localparam logic [1:0] E_MIS = 2'b11;

  logic [1:0]    state;
  logic [CW-1:0] tcnt;
  logic          go;
  logic          bad;
  logic [1:0]    code_n;
  logic [31:0]   data_n;
  logic          misal;

  assign misal = (dma_addr[1:0] != 2'b00);

  // Response for the edge that enters RESP; m_we_o doubles as the latched direction in BUS.
  always_comb begin
    go     = 1'b0;
    bad    = 1'b0;
    code_n = E_BUS;
    data_n = '0;
    unique case (state)
      S_IDLE: begin
        if (dma_req && misal) begin
          go     = 1'b1;
          bad    = 1'b1;
          code_n = E_MIS;
          data_n = dma_we ? '0 : ERR_DATA;
        end
      end
      S_BUS: begin
        if (m_ack_i) begin
          go     = 1'b1;
          data_n = m_we_o ? '0 : m_dat_i;
        end else if (m_err_i) begin
          go     = 1'b1;
          bad    = 1'b1;
          code_n = E_BUS;
          data_n = m_we_o ? '0 : ERR_DATA;
        end else if (tcnt == TMO_LAST) begin
          go     = 1'b1;
          bad    = 1'b1;
          code_n = E_TMO;
          data_n = m_we_o ? '0 : ERR_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
      m_sel_o    <= '0;
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
      err_o      <= 1'b0;
      err_code   <= '0;
      xfer_count <= '0;
    end else begin
      dma_ack   <= go;
      dma_rdata <= data_n;
      if (go) begin
        xfer_count <= xfer_count + 16'd1;
      end
      // A failure landing with err_clr wins and reloads the code.
      if (go && bad) begin
        err_o <= 1'b1;
        if (!err_o || err_clr) begin
          err_code <= code_n;
        end
      end else if (err_clr) begin
        err_o    <= 1'b0;
        err_code <= '0;
      end
      unique case (state)
        S_IDLE: begin
          if (dma_req) begin
            if (misal) begin
              state <= S_RESP;
            end else begin
              state   <= S_BUS;
              tcnt    <= '0;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= dma_we;
              m_adr_o <= dma_addr;
              m_dat_o <= dma_wdata;
              m_sel_o <= 4'hF;
            end
          end
        end
        S_BUS: begin
          if (go) begin
            state   <= S_RESP;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_sel_o <= 4'h0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: state <= S_GAP;
        S_GAP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_dma_bridge.sv
// Bench for matrix_dma_bridge: directed cases plus random traffic
// against a transfer-level reference model and a behavioural slave.
module tb_matrix_dma_bridge;

  localparam int TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        m_err_i = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_o;
  logic [1:0]  err_code;
  logic [15:0] xfer_count;

  always #5 clk = ~clk;

  matrix_dma_bridge #(.TIMEOUT_CYC(TMO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .err_clr(err_clr), .err_o(err_o), .err_code(err_code),
    .xfer_count(xfer_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  int tick = 0;

  always @(posedge clk) tick <= tick + 1;

  // Behavioural slave: mode 0 ack, 1 silent, 2 err, 3 ack+err
  int slv_waits = 0;
  int slv_mode = 0;
  int wcnt = 0;
  logic [31:0] smem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (smem.exists(a)) return smem[a];
    return dflt(a);
  endfunction

  always @(negedge clk) begin
    logic s;
    s = m_cyc_o && m_stb_o;
    m_dat_i = (s && !m_we_o) ? slv_rd(m_adr_o) : 32'h0;
    m_ack_i = s && (wcnt == slv_waits) && (slv_mode == 0 || slv_mode == 3);
    m_err_i = s && (wcnt == slv_waits) && (slv_mode >= 2);
  end

  always @(posedge clk) begin
    if (m_cyc_o && m_stb_o) begin
      if (m_ack_i && m_we_o) smem[m_adr_o] = m_dat_o;
      wcnt <= (m_ack_i || m_err_i) ? 0 : wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // Bus monitor
  int bus_cnt = 0;
  int stb_cyc = 0;
  bit in_cyc = 0;
  bit unstable = 0;
  logic [31:0] adr_q[$];
  logic [31:0] f_adr, f_dat;
  logic f_we;

  always @(negedge clk) begin
    if (m_cyc_o && m_stb_o) begin
      if (!in_cyc) begin
        bus_cnt++;
        adr_q.push_back(m_adr_o);
        f_adr = m_adr_o;
        f_dat = m_dat_o;
        f_we = m_we_o;
        if (m_sel_o !== 4'hF) unstable = 1;
      end else if (m_adr_o !== f_adr || m_dat_o !== f_dat ||
                   m_we_o !== f_we || m_sel_o !== 4'hF) begin
        unstable = 1;
      end
      stb_cyc++;
      in_cyc = 1;
    end else begin
      in_cyc = 0;
    end
  end

  // Reference model state
  logic [15:0] exp_cnt = '0;
  bit          exp_err = 0;
  logic [1:0]  exp_code = '0;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"}, 32'(xfer_count), 32'(exp_cnt));
    chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
    chk({tag, "_code"}, 32'(err_code), 32'(exp_code));
  endtask

  // One transfer; called and returns at a negedge with the DUT in IDLE.
  task automatic xfer(input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input int waits,
                      input int mode, input bit hold_clr,
                      input string tag);
    int bus_cyc;
    bit ok;
    logic [1:0] c;
    logic [31:0] er;
    int n;
    int b0, s0;
    c = 2'b00;
    if (a[1:0] != 2'b00) begin
      ok = 0; c = 2'b11; bus_cyc = 0;
    end else if (mode == 0 || mode == 3) begin
      ok = 1; bus_cyc = waits + 1;
    end else if (mode == 2) begin
      ok = 0; c = 2'b01; bus_cyc = waits + 1;
    end else begin
      ok = 0; c = 2'b10; bus_cyc = TMO;
    end
    er = we ? 32'h0 : (ok ? ref_rd(a) : ERRD);
    slv_waits = waits;
    slv_mode = mode;
    b0 = bus_cnt;
    s0 = stb_cyc;
    unstable = 0;
    dma_req = 1;
    dma_we = we;
    dma_addr = a;
    dma_wdata = wd;
    err_clr = hold_clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_ack && n < 100);
    chk({tag, "_lat"}, 32'(n + 1), 32'(bus_cyc + 2));
    chk({tag, "_rdata"}, dma_rdata, er);
    dma_req = 0;
    err_clr = 0;
    exp_cnt = exp_cnt + 16'd1;
    if (hold_clr) begin
      exp_err = 0;
      exp_code = 2'b00;
    end
    if (!ok) begin
      if (!exp_err) exp_code = c;
      exp_err = 1;
    end
    if (ok && we) ref_mem[a] = wd;
    @(negedge clk);
    chk({tag, "_ack1"}, 32'(dma_ack), 32'h0);
    chk({tag, "_rd0"}, dma_rdata, 32'h0);
    chk_state(tag);
    chk({tag, "_nbus"}, 32'(bus_cnt - b0), 32'(bus_cyc > 0 ? 1 : 0));
    chk({tag, "_nstb"}, 32'(stb_cyc - s0), 32'(bus_cyc));
    chk({tag, "_stable"}, 32'(unstable), 32'h0);
    if (bus_cyc > 0) begin
      chk({tag, "_adr"}, adr_q[$], a);
      chk({tag, "_we"}, 32'(f_we), 32'(we));
      if (we) chk({tag, "_wdat"}, f_dat, wd);
    end
    if (ok && we) chk({tag, "_mem"}, slv_rd(a), wd);
    @(negedge clk);
  endtask

  initial begin
    int n, last, b0, acks;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(dma_ack), 32'h0);
    chk("rst_rdata", dma_rdata, 32'h0);
    chk("rst_cyc", 32'(m_cyc_o), 32'h0);
    chk("rst_stb", 32'(m_stb_o), 32'h0);
    chk("rst_sel", 32'(m_sel_o), 32'h0);
    chk("rst_adr", m_adr_o, 32'h0);
    chk_state("rst");
    reset = 0;
    @(negedge clk);

    smem[32'h1000] = 32'h12345678;
    ref_mem[32'h1000] = 32'h12345678;
    xfer(0, 32'h1000, 32'h0, 0, 0, 0, "t1_read");
    chk("t1_value", dma_rdata === 32'h0 ? ref_rd(32'h1000) : 32'h0,
        32'h12345678);

    // Back-to-back reads with req held high
    slv_mode = 0;
    slv_waits = 0;
    b0 = bus_cnt;
    a = 32'h4000;
    dma_we = 0;
    dma_addr = a;
    dma_req = 1;
    last = 0;
    for (int k = 0; k < 64; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!dma_ack && n < 20);
      chk("t2_ackseen", 32'(dma_ack), 32'h1);
      chk("t2_rdata", dma_rdata, ref_rd(a));
      if (k > 0) chk("t2_spacing", 32'(tick - last), 32'd4);
      last = tick;
      exp_cnt = exp_cnt + 16'd1;
      a = a + 32'd4;
      dma_addr = a;
      if (k == 63) dma_req = 0;
    end
    @(negedge clk);
    chk("t2_nbus", 32'(bus_cnt - b0), 32'd64);
    for (int i = 0; i < 64; i++)
      chk("t2_adr", adr_q[b0 + i], 32'h4000 + 32'(i * 4));
    chk_state("t2");
    @(negedge clk);

    xfer(1, 32'h2004, 32'hCAFEF00D, 3, 0, 0, "t3_write");

    xfer(0, 32'h5000, 32'h0, 0, 1, 0, "t4_tmo");
    xfer(0, 32'h5004, 32'h0, 1, 2, 0, "t4_berr");
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    exp_err = 0;
    exp_code = 2'b00;
    chk_state("t4_clr");

    xfer(0, 32'h3002, 32'h0, 0, 0, 0, "t5_mis");
    xfer(1, 32'h3005, 32'h11112222, 0, 0, 0, "t5_mis_wr");
    xfer(0, 32'h3008, 32'h0, 0, 2, 1, "t5_clr_berr");
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    exp_err = 0;
    exp_code = 2'b00;

    xfer(0, 32'h7000, 32'h0, 0, 3, 0, "t6_ackerr");
    xfer(0, 32'h7004, 32'h0, 2, 3, 0, "t6_ackerr_w");

    for (int k = 0; k < 40; k++) begin
      bit we;
      int md;
      logic [31:0] ra;
      we = $urandom_range(0, 1) == 1;
      ra = 32'h6000 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
      md = $urandom_range(0, 9);
      md = (md < 7) ? 0 : (md == 7) ? 2 : (md == 8) ? 3 : 1;
      xfer(we, ra, $urandom, $urandom_range(0, 3), md, 0, "rnd");
    end

    // Reset while the bus cycle is open
    slv_mode = 1;
    dma_we = 0;
    dma_addr = 32'h8000;
    dma_req = 1;
    repeat (3) @(negedge clk);
    chk("t7_inbus", 32'(m_cyc_o), 32'h1);
    reset = 1;
    dma_req = 0;
    @(negedge clk);
    exp_cnt = '0;
    exp_err = 0;
    exp_code = 2'b00;
    chk("t7_cyc", 32'(m_cyc_o), 32'h0);
    chk("t7_stb", 32'(m_stb_o), 32'h0);
    chk("t7_ack", 32'(dma_ack), 32'h0);
    chk_state("t7");
    reset = 0;
    slv_mode = 0;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (dma_ack) acks++;
    end
    chk("t7_noack", 32'(acks), 32'h0);
    chk("t7_cnt_after", 32'(xfer_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
